// File: rtl/pipelined_adder.sv
// pipelined_adder: valid/ready adder, one CHUNK slice per stage; ports clk/rst, in_valid/in_ready/a/b/c_in in, out_valid/out_ready/s/c_out/overflow out
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow
);
  localparam int STAGES = WIDTH / CHUNK;
  logic w_adv;
  assign w_adv = !out_valid || out_ready;
  assign in_ready = w_adv;
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int UW = WIDTH - k * CHUNK;
    logic [UW-1:0]          w_a, w_b;
    logic                   w_v, w_c;
    logic [CHUNK:0]         w_sum;
    logic [(k+1)*CHUNK-1:0] w_s, r_s;
    logic                   r_v, r_c;
    if (k == 0) begin : g_in
      assign w_a = a;
      assign w_b = b;
      assign w_v = in_valid;
      assign w_c = c_in;
      assign w_s = w_sum[CHUNK-1:0];
    end else begin : g_in
      assign w_a = g_st[k-1].g_up.r_a;
      assign w_b = g_st[k-1].g_up.r_b;
      assign w_v = g_st[k-1].r_v;
      assign w_c = g_st[k-1].r_c;
      assign w_s = {w_sum[CHUNK-1:0], g_st[k-1].r_s};
    end
    assign w_sum = {1'b0, w_a[CHUNK-1:0]} + {1'b0, w_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, w_c};
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v <= 1'b0;
        r_c <= 1'b0;
        r_s <= '0;
      end else if (w_adv) begin
        r_v <= w_v;
        r_c <= w_sum[CHUNK];
        r_s <= w_s;
      end
    end
    if (k < STAGES - 1) begin : g_up
      logic [UW-CHUNK-1:0] r_a, r_b;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[UW-1:CHUNK];
          r_b <= w_b[UW-1:CHUNK];
        end
      end
    end else begin : g_last
      logic r_ovf;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_ovf <= 1'b0;
        else if (w_adv) r_ovf <= w_a[CHUNK-1] ^ w_b[CHUNK-1] ^ w_sum[CHUNK-1] ^ w_sum[CHUNK];
      end
      assign out_valid = r_v;
      assign s         = r_s;
      assign c_out     = r_c;
      assign overflow  = r_ovf;
    end
  end
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: scoreboard bench for 16/4 and 4/4 pipelined_adder instances
module tb_pipelined_adder;
  logic clk, rst;
  logic in_valid, in_ready, c_in, out_valid, out_ready, c_out, overflow;
  logic [15:0] a, b, s;
  logic iv4, ir4, ci4, ov4, or4, co4, of4;
  logic [3:0] a4, b4, s4;
  logic [17:0] exp16;
  logic [5:0] exp4;
  logic [17:0] q16[$];
  logic [5:0] q4[$];
  int total = 0, bad = 0;
  logic d16, d4;
  typedef struct {
    logic [15:0] a, b;
    logic ci;
    logic [15:0] s;
    logic c, o;
  } vec_t;
  vec_t tbl[7];
  pipelined_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .c_out(c_out), .overflow(overflow));
  pipelined_adder #(.WIDTH(4), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4), .c_in(ci4),
    .out_valid(ov4), .out_ready(or4), .s(s4), .c_out(co4), .overflow(of4));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, want);
    end
  endtask
  function automatic logic [17:0] m16(input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [16:0] t;
    t = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    return {t[15:0], t[16], (x[15] == y[15]) && (t[15] != x[15])};
  endfunction
  function automatic logic [5:0] m4(input logic [3:0] x, input logic [3:0] y, input logic ci);
    logic [4:0] t;
    t = {1'b0, x} + {1'b0, y} + {4'd0, ci};
    return {t[3:0], t[4], (x[3] == y[3]) && (t[3] != x[3])};
  endfunction
  always @(negedge clk) begin
    if (rst) q16.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q16.size() == 0) chk("unexpected16", 1, 0);
        else chk("res16", {14'd0, s, c_out, overflow}, {14'd0, q16.pop_front()});
      end
      if (in_valid && in_ready) q16.push_back(exp16);
    end
  end
  always @(negedge clk) begin
    if (rst) q4.delete();
    else begin
      if (ov4 && or4) begin
        if (q4.size() == 0) chk("unexpected4", 1, 0);
        else chk("res4", {26'd0, s4, co4, of4}, {26'd0, q4.pop_front()});
      end
      if (iv4 && ir4) q4.push_back(exp4);
    end
  end
  task automatic send16(input logic [15:0] x, input logic [15:0] y, input logic ci, input logic [17:0] e);
    int t = 0;
    a = x; b = y; c_in = ci; exp16 = e; in_valid = 1;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send16_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid = 0;
  endtask
  task automatic send4(input logic [3:0] x, input logic [3:0] y, input logic ci, input logic [5:0] e);
    int t = 0;
    a4 = x; b4 = y; ci4 = ci; exp4 = e; iv4 = 1;
    @(negedge clk);
    while (!ir4 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send4_timeout", 0, 1);
    @(posedge clk);
    #1 iv4 = 0;
  endtask
  task automatic drain;
    int t = 0;
    out_ready = 1; or4 = 1;
    while ((q16.size() != 0 || q4.size() != 0 || out_valid || ov4) && t < 300) begin
      @(posedge clk);
      #2 t++;
    end
    chk("drain", q16.size() + q4.size(), 0);
  endtask
  initial begin
    int lat, stale;
    tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[2] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1};
    tbl[3] = '{16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0};
    tbl[4] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
    tbl[5] = '{16'h00FF, 16'h0F01, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    rst = 1; in_valid = 0; iv4 = 0; out_ready = 1; or4 = 1;
    a = 0; b = 0; c_in = 0; a4 = 0; b4 = 0; ci4 = 0; exp16 = 0; exp4 = 0; d16 = 0; d4 = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s, 0);
    chk("rst_flags", {c_out, overflow}, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid4", ov4, 0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0;
    a = tbl[0].a; b = tbl[0].b; c_in = tbl[0].ci; exp16 = {tbl[0].s, tbl[0].c, tbl[0].o}; in_valid = 1;
    @(posedge clk);
    #1 in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    chk("latency16", lat, 4);
    drain();
    a4 = 4'd2; b4 = 4'd2; ci4 = 0; exp4 = {4'd4, 1'b0, 1'b0}; iv4 = 1;
    @(posedge clk);
    #1 iv4 = 0;
    chk("latency4_valid", ov4, 1);
    chk("latency4_s", s4, 4);
    drain();
    for (int i = 1; i < 3; i++) send16(tbl[i].a, tbl[i].b, tbl[i].ci, {tbl[i].s, tbl[i].c, tbl[i].o});
    drain();
    for (int i = 3; i < 7; i++) send16(tbl[i].a, tbl[i].b, tbl[i].ci, {tbl[i].s, tbl[i].c, tbl[i].o});
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1 lat++;
    end
    for (int i = 3; i < 7; i++) begin
      chk("b2b_valid", out_valid, 1);
      chk("b2b_sum", {s, c_out, overflow}, {tbl[i].s, tbl[i].c, tbl[i].o});
      @(posedge clk);
      #1;
    end
    drain();
    fork
      begin
        for (int i = 0; i < 6; i++)
          send16(16'(16'h1111 * (i + 1)), 16'(16'h0F0F + i), i[0], m16(16'(16'h1111 * (i + 1)), 16'(16'h0F0F + i), i[0]));
      end
      begin
        int t = 0;
        logic [15:0] s0;
        s0 = 0;
        while (!out_valid && t < 50) begin
          @(posedge clk);
          #1 t++;
        end
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          if (i == 0) s0 = s;
          else chk("stall_hold", s, s0);
        end
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();
    send16(16'h8001, 16'h8000, 0, m16(16'h8001, 16'h8000, 0));
    send16(16'h1234, 16'h1111, 0, m16(16'h1234, 16'h1111, 0));
    send16(16'h0F0F, 16'h0101, 1, m16(16'h0F0F, 16'h0101, 1));
    @(posedge clk);
    #1 out_ready = 0;
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_sum", {s, c_out, overflow}, {16'h0001, 1'b1, 1'b1});
    #1 rst = 1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_s", s, 0);
    chk("arst_flags", {c_out, overflow}, 0);
    chk("arst_in_ready", in_ready, 1);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 0; out_ready = 1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale", stale, 0);
    send16(16'd2, 16'd2, 0, {16'd4, 1'b0, 1'b0});
    drain();
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic [15:0] x, y;
          logic ci;
          x = 16'($urandom); y = 16'($urandom); ci = 1'($urandom);
          send16(x, y, ci, m16(x, y, ci));
        end
        d16 = 1;
      end
      begin
        for (int i = 0; i < 1000; i++) begin
          logic [3:0] x, y;
          logic ci;
          x = 4'($urandom); y = 4'($urandom); ci = 1'($urandom);
          send4(x, y, ci, m4(x, y, ci));
        end
        d4 = 1;
      end
      begin
        while (!(d16 && d4)) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom); or4 = 1'($urandom);
        end
      end
    join
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
